// File: rtl/floor_call_pkg.sv
// Shared definitions for the floor call panel: per-floor call state encoding
// and the width helper for the controller floor index.
package floor_call_pkg;

    typedef enum logic {
        CALL_IDLE    = 1'b0,
        CALL_PENDING = 1'b1
    } call_state_t;

    // Width of a floor index; a single-floor build still gets a 1-bit bus.
    function automatic int floor_w(input int num_floors);
        return (num_floors > 1) ? $clog2(num_floors) : 1;
    endfunction

endpackage

// File: rtl/call_debounce.sv
// One call button: two-flop synchronizer, stability counter and debounced
// level. rise is a registered one-cycle pulse on each accepted 0->1 change.
module call_debounce #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic sync_a;
    logic sync_b;
    logic [CNT_W-1:0] stable_cnt;

    // Synchronize the raw button, then flip the level only after an unbroken
    // run of disagreeing samples; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_a     <= 1'b0;
            sync_b     <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            rise   <= 1'b0;
            if (sync_b != level) begin
                if (stable_cnt == CNT_LAST) begin
                    level      <= sync_b;
                    rise       <= sync_b;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/floor_call_panel.sv
// Floor call panel: debounces the call buttons, latches calls per floor,
// pulses req to the elevator controller and drives the call lamps. A call
// clears when the controller reports the door open at that floor.
// Optional feature macro FLOOR_CALL_RETRY_EN: unserved calls re-pulse req
// every RETRY_CYCLES cycles while pending.
module floor_call_panel
    import floor_call_pkg::*;
#(
    parameter int NUM_FLOORS      = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int RETRY_CYCLES    = 64,
    localparam int FLOOR_W        = floor_w(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  door,
    output logic [NUM_FLOORS-1:0] req,
    output logic [NUM_FLOORS-1:0] lamp,
    output logic                  any_call
);

    logic [NUM_FLOORS-1:0] deb_level;
    logic [NUM_FLOORS-1:0] deb_rise;
    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] served;

    call_state_t           state     [NUM_FLOORS];
    call_state_t           state_nxt [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] req_nxt;
    logic [NUM_FLOORS-1:0] lamp_nxt;

`ifdef FLOOR_CALL_RETRY_EN
    localparam int RETRY_W = $clog2(RETRY_CYCLES);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_CYCLES - 1);

    logic [RETRY_W-1:0] retry_cnt     [NUM_FLOORS];
    logic [RETRY_W-1:0] retry_cnt_nxt [NUM_FLOORS];
`endif

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_floor
        call_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .btn    (btn[g]),
            .level  (deb_level[g]),
            .rise   (deb_rise[g])
        );

        // A rise always coincides with a high level; the AND keeps the press
        // definition tied to the debounced level itself.
        assign press[g]  = deb_rise[g] & deb_level[g];
        // Out-of-range floor codes compare unequal to every index.
        assign served[g] = door && (floor == FLOOR_W'(g));
    end

    // Next-state for every floor; service always wins over a same-cycle press.
    always_comb begin
        for (int i = 0; i < NUM_FLOORS; i++) begin
            state_nxt[i] = state[i];
            req_nxt[i]   = 1'b0;
`ifdef FLOOR_CALL_RETRY_EN
            retry_cnt_nxt[i] = retry_cnt[i];
`endif
            case (state[i])
                CALL_IDLE: begin
                    if (press[i] && !served[i]) begin
                        state_nxt[i] = CALL_PENDING;
                        req_nxt[i]   = 1'b1;
`ifdef FLOOR_CALL_RETRY_EN
                        retry_cnt_nxt[i] = '0;
`endif
                    end
                end
                CALL_PENDING: begin
                    if (served[i]) begin
                        state_nxt[i] = CALL_IDLE;
`ifdef FLOOR_CALL_RETRY_EN
                        retry_cnt_nxt[i] = '0;
`endif
                    end else begin
`ifdef FLOOR_CALL_RETRY_EN
                        if (retry_cnt[i] == RETRY_LAST) begin
                            req_nxt[i]       = 1'b1;
                            retry_cnt_nxt[i] = '0;
                        end else begin
                            retry_cnt_nxt[i] = retry_cnt[i] + 1'b1;
                        end
`endif
                    end
                end
                default: state_nxt[i] = CALL_IDLE;
            endcase
            lamp_nxt[i] = (state_nxt[i] == CALL_PENDING);
        end
    end

    // Register call states and all outputs; any_call tracks lamp on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                state[i] <= CALL_IDLE;
`ifdef FLOOR_CALL_RETRY_EN
                retry_cnt[i] <= '0;
`endif
            end
            req      <= '0;
            lamp     <= '0;
            any_call <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                state[i] <= state_nxt[i];
`ifdef FLOOR_CALL_RETRY_EN
                retry_cnt[i] <= retry_cnt_nxt[i];
`endif
            end
            req      <= req_nxt;
            lamp     <= lamp_nxt;
            any_call <= |lamp_nxt;
        end
    end

endmodule

// File: tb/tb_floor_call_panel.sv
// Bench for floor_call_panel: directed scenarios followed by random button,
// floor and door activity, all checked against an edge-level reference model.
module tb_floor_call_panel;

    localparam int NF = 4;
    localparam int DB = 4;
    localparam int RT = 16;

    logic          clk;
    logic          reset_n;
    logic [NF-1:0] btn;
    logic [1:0]    floor;
    logic          door;
    logic [NF-1:0] req;
    logic [NF-1:0] lamp;
    logic          any_call;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    floor_call_panel #(
        .NUM_FLOORS     (NF),
        .DEBOUNCE_CYCLES(DB),
        .RETRY_CYCLES   (RT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn),
        .floor   (floor),
        .door    (door),
        .req     (req),
        .lamp    (lamp),
        .any_call(any_call)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Button samples reach the debouncer two edges late; a level changes
    // once the last DB delivered samples all disagree with it. A press
    // becomes visible to the call logic one edge after the level rises.
    bit          raw_hist  [NF][$];
    bit          sync_hist [NF][$];
    bit          lvl_m     [NF];
    bit          rise_m    [NF];
    bit          pend_m    [NF];
    int          entry_m   [NF];
    int          edge_n = 0;
    logic [NF-1:0] req_m;
    logic [NF-1:0] lamp_m;
    logic          any_m;

    always @(posedge clk) begin
        edge_n++;
        if (!reset_n) begin
            for (int i = 0; i < NF; i++) begin
                raw_hist[i].delete();
                sync_hist[i].delete();
                lvl_m[i]  = 1'b0;
                rise_m[i] = 1'b0;
                pend_m[i] = 1'b0;
            end
            req_m  = '0;
            lamp_m = '0;
            any_m  = 1'b0;
        end else begin
            for (int i = 0; i < NF; i++) begin
                bit served, pulse, synced, all_diff;
                served = door && (int'(floor) == i);
                pulse  = 1'b0;
                if (pend_m[i]) begin
                    if (served) begin
                        pend_m[i] = 1'b0;
                    end else begin
`ifdef FLOOR_CALL_RETRY_EN
                        if (((edge_n - entry_m[i]) % RT) == 0) pulse = 1'b1;
`endif
                    end
                end else if (rise_m[i] && !served) begin
                    pend_m[i]  = 1'b1;
                    entry_m[i] = edge_n;
                    pulse      = 1'b1;
                end
                req_m[i]  = pulse;
                lamp_m[i] = pend_m[i];

                synced = (raw_hist[i].size() >= 2) ? raw_hist[i][raw_hist[i].size() - 2] : 1'b0;
                raw_hist[i].push_back(btn[i]);
                if (raw_hist[i].size() > 2) void'(raw_hist[i].pop_front());
                sync_hist[i].push_back(synced);
                if (sync_hist[i].size() > DB) void'(sync_hist[i].pop_front());

                rise_m[i] = 1'b0;
                if (sync_hist[i].size() == DB) begin
                    all_diff = 1'b1;
                    foreach (sync_hist[i][k])
                        if (sync_hist[i][k] == lvl_m[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        lvl_m[i]  = ~lvl_m[i];
                        rise_m[i] = lvl_m[i];
                    end
                end
            end
            any_m = |lamp_m;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_val("req", req, req_m);
            check_val("lamp", lamp, lamp_m);
            check_val("any_call", any_call, any_m);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Edges until req[idx] is seen high, -1 if not within max_n.
    task automatic wait_pulse(input int idx, input int max_n, output int n, output logic [NF-1:0] seen);
        n    = -1;
        seen = '0;
        for (int k = 1; k <= max_n; k++) begin
            step(1);
            if (req[idx]) begin
                n    = k;
                seen = req;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int idx, input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            step(1);
            if (req[idx]) cnt++;
        end
    endtask

    initial begin
        int            n;
        int            cnt;
        logic [NF-1:0] seen;
        reset_n = 1'b0;
        btn     = '0;
        floor   = 2'd0;
        door    = 1'b0;
        step(3);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        check_val("rst_req", req, 0);
        check_val("rst_lamp", lamp, 0);
        check_val("rst_any", any_call, 0);

        // Scenario 1: single call, latency and pulse shape.
        btn[2] = 1'b1;
        wait_pulse(2, 20, n, seen);
        check_val("s1_latency", n, 7);
        check_val("s1_req", seen, 4'b0100);
        count_pulses(2, 12, cnt);
        check_val("s1_no_repulse", cnt, 0);
        check_val("s1_lamp", lamp, 4'b0100);
        check_val("s1_any", any_call, 1);
        floor = 2'd2; door = 1'b1;
        step(1);
        door = 1'b0; btn = '0;
        check_val("s1_served", lamp, 0);
        step(10);

        // Scenario 2: short glitch is rejected.
        btn[1] = 1'b1;
        step(3);
        btn[1] = 1'b0;
        count_pulses(1, 12, cnt);
        check_val("s2_pulses", cnt, 0);
        check_val("s2_lamp", lamp, 0);

        // Scenario 3: service at another floor leaves the call, own floor clears it.
        btn[3] = 1'b1;
        step(10);
        check_val("s3_lamp_set", lamp[3], 1);
        btn[3] = 1'b0;
        floor = 2'd2; door = 1'b1;
        step(1);
        check_val("s3_other_floor", lamp[3], 1);
        floor = 2'd3;
        step(1);
        door = 1'b0;
        check_val("s3_cleared", lamp[3], 0);
        step(10);

        // Scenario 4: press during service is absorbed; two floors at once.
        floor = 2'd0; door = 1'b1;
        btn[0] = 1'b1;
        count_pulses(0, 12, cnt);
        check_val("s4_absorbed_pulses", cnt, 0);
        check_val("s4_absorbed_lamp", lamp[0], 0);
        btn[0] = 1'b0;
        step(10);
        door = 1'b0; floor = 2'd1;
        btn = 4'b1001;
        wait_pulse(3, 20, n, seen);
        check_val("s4_latency", n, 7);
        check_val("s4_req_pair", seen, 4'b1001);
        // Scenario 6: unserved call, retry behaviour over 63 further cycles.
        count_pulses(3, 63, cnt);
`ifdef FLOOR_CALL_RETRY_EN
        check_val("s6_retry_pulses", cnt, 3);
`else
        check_val("s6_single_pulse", cnt, 0);
`endif
        btn = '0;
        door = 1'b1; floor = 2'd0;
        step(1);
        floor = 2'd3;
        step(1);
        door = 1'b0;
        step(10);
        check_val("s4_all_clear", lamp, 0);

        // Scenario 5: reset while a call is pending and the button is held.
        btn[1] = 1'b1;
        step(10);
        check_val("s5_lamp_set", lamp[1], 1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        check_val("s5_rst_lamp", lamp, 0);
        check_val("s5_rst_any", any_call, 0);
        wait_pulse(1, 20, n, seen);
        check_val("s5_requalify", n, 7);
        btn = '0;
        step(10);

        // Random activity: slowly toggling buttons, random floor and door.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NF; i++)
                if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
            floor = 2'($urandom_range(0, 3));
            door  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
            else reset_n = 1'b1;
            step(1);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
